// File: rtl/pwm_audio_pkg.sv
// Shared types and helpers for the stereo PWM audio receiver.
// Optional smoothing is enabled by defining PWM_AUDIO_IN_SMOOTH_EN.
package pwm_audio_pkg;

    localparam int PWM_BITS_DEF = 8;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_e;

    // Clamp a high-time count to the largest value representable in `bits` bits.
    function automatic logic [31:0] sat_count(input logic [31:0] cnt, input int bits);
        logic [31:0] max_v;
        max_v = (32'd1 << bits) - 32'd1;
        return (cnt > max_v) ? max_v : cnt;
    endfunction

endpackage

// File: rtl/pwm_duty_counter.sv
// One PWM channel: synchronizer, rising-edge detect, high-time accumulator, saturation.
// Smoothing against the previous latched value is present only with PWM_AUDIO_IN_SMOOTH_EN.
module pwm_duty_counter
    import pwm_audio_pkg::*;
#(
    parameter int PWM_BITS    = PWM_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                aclr,
    input  logic                pwm,
    input  logic                cnt_en,
    input  logic                pos0,
    input  logic                frame_end,
    input  logic                hist_clr,
    output logic                rise,
    output logic [PWM_BITS-1:0] sample
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [PWM_BITS:0]      acc_q;
    logic [PWM_BITS:0]      acc_d;
    logic [PWM_BITS:0]      bit_ext;
    logic [PWM_BITS:0]      total;
    logic [PWM_BITS-1:0]    sat;
    logic                   pwm_sync;

    assign pwm_sync = sync_q[SYNC_STAGES-1];
    assign rise     = pwm_sync & ~prev_q;
    assign bit_ext  = {{PWM_BITS{1'b0}}, pwm_sync};
    assign total    = acc_q + bit_ext;
    assign sat      = PWM_BITS'(sat_count(32'(total), PWM_BITS));

    // Position 0 restarts the count with the current bit so no separate clear cycle is needed.
    always_comb begin
        acc_d = '0;
        if (cnt_en) begin
            acc_d = pos0 ? bit_ext : total;
        end
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            acc_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm};
            prev_q <= pwm_sync;
            acc_q  <= acc_d;
        end
    end

`ifdef PWM_AUDIO_IN_SMOOTH_EN
    logic [PWM_BITS-1:0] hist_q;
    logic                hist_vld_q;
    logic [PWM_BITS:0]   avg_sum;
    logic [PWM_BITS-1:0] avg;
    logic                avg_unused_lsb;

    assign avg_sum                 = {1'b0, hist_q} + {1'b0, sat} + (PWM_BITS+1)'(1);
    assign {avg, avg_unused_lsb}   = avg_sum;
    assign sample                  = hist_vld_q ? avg : sat;

    always_ff @(posedge clk) begin
        if (aclr || hist_clr) begin
            hist_q     <= '0;
            hist_vld_q <= 1'b0;
        end else if (frame_end) begin
            hist_q     <= sample;
            hist_vld_q <= 1'b1;
        end
    end
`else
    logic hist_clr_unused;
    assign hist_clr_unused = hist_clr;
    assign sample          = sat;
`endif

endmodule

// File: rtl/pwm_audio_stereo_in.sv
// Stereo PWM receiver top: frame alignment FSM on the left channel, frame counter, valid/ready output.
// Feature macro: PWM_AUDIO_IN_SMOOTH_EN enables per-channel two-frame smoothing.
module pwm_audio_stereo_in
    import pwm_audio_pkg::*;
#(
    parameter int PWM_BITS    = PWM_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                aclr,
    input  logic                left_pwm,
    input  logic                right_pwm,
    output logic [PWM_BITS-1:0] left_sample,
    output logic [PWM_BITS-1:0] right_sample,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                locked,
    output logic                overrun,
    output logic                resync
);

    localparam logic [PWM_BITS-1:0] FRAME_LAST = '1;

    state_e              state_q;
    logic [PWM_BITS-1:0] frame_cnt_q;
    logic [PWM_BITS-1:0] frame_cnt_d;
    logic [PWM_BITS-1:0] pos;
    logic [PWM_BITS-1:0] left_sample_q;
    logic [PWM_BITS-1:0] right_sample_q;
    logic [PWM_BITS-1:0] left_new;
    logic [PWM_BITS-1:0] right_new;
    logic                valid_q;
    logic                overrun_q;
    logic                resync_q;
    logic                left_rise;
    logic                right_rise_unused;
    logic                cnt_en;
    logic                pos0;
    logic                frame_end;
    logic                misalign;

    // Any left rising edge marks position 0: a fresh lock in HUNT, a restart if it lands mid-frame.
    assign pos         = left_rise ? '0 : frame_cnt_q;
    assign cnt_en      = (state_q == LOCK) || left_rise;
    assign pos0        = cnt_en && (pos == '0);
    assign frame_end   = (state_q == LOCK) && (pos == FRAME_LAST);
    assign misalign    = (state_q == LOCK) && left_rise && (frame_cnt_q != '0);
    assign frame_cnt_d = cnt_en ? pos + PWM_BITS'(1) : '0;

    pwm_duty_counter #(.PWM_BITS(PWM_BITS), .SYNC_STAGES(SYNC_STAGES)) u_left (
        .clk       (clk),
        .aclr      (aclr),
        .pwm       (left_pwm),
        .cnt_en    (cnt_en),
        .pos0      (pos0),
        .frame_end (frame_end),
        .hist_clr  (misalign),
        .rise      (left_rise),
        .sample    (left_new)
    );

    pwm_duty_counter #(.PWM_BITS(PWM_BITS), .SYNC_STAGES(SYNC_STAGES)) u_right (
        .clk       (clk),
        .aclr      (aclr),
        .pwm       (right_pwm),
        .cnt_en    (cnt_en),
        .pos0      (pos0),
        .frame_end (frame_end),
        .hist_clr  (misalign),
        .rise      (right_rise_unused),
        .sample    (right_new)
    );

    always_ff @(posedge clk) begin
        if (aclr) begin
            state_q        <= HUNT;
            frame_cnt_q    <= '0;
            left_sample_q  <= '0;
            right_sample_q <= '0;
            valid_q        <= 1'b0;
            overrun_q      <= 1'b0;
            resync_q       <= 1'b0;
        end else begin
            if (left_rise) begin
                state_q <= LOCK;
            end
            frame_cnt_q <= frame_cnt_d;
            resync_q    <= misalign;
            overrun_q   <= frame_end && valid_q && !sample_ready;
            // A latch coinciding with a transfer keeps valid high: the old pair leaves, the new one loads.
            if (frame_end) begin
                left_sample_q  <= left_new;
                right_sample_q <= right_new;
                valid_q        <= 1'b1;
            end else if (valid_q && sample_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign left_sample  = left_sample_q;
    assign right_sample = right_sample_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign resync       = resync_q;
    assign locked       = (state_q == LOCK);

endmodule

// File: tb/tb_pwm_audio_stereo_in.sv
// Scoreboard bench for pwm_audio_stereo_in: frame-window reference model feeds an expected-pair queue.
// Honors PWM_AUDIO_IN_SMOOTH_EN in the reference model.
module tb_pwm_audio_stereo_in;

    localparam int PB    = 8;
    localparam int SS    = 2;
    localparam int FRAME = 256;

    typedef struct {
        int l;
        int r;
    } pair_t;

    logic          clk = 1'b0;
    logic          aclr;
    logic          left_pwm;
    logic          right_pwm;
    logic          sample_ready;
    logic [PB-1:0] left_sample;
    logic [PB-1:0] right_sample;
    logic          sample_valid;
    logic          locked;
    logic          overrun;
    logic          resync;

    always #5 clk = ~clk;

    pwm_audio_stereo_in #(.PWM_BITS(PB), .SYNC_STAGES(SS)) dut (
        .clk          (clk),
        .aclr         (aclr),
        .left_pwm     (left_pwm),
        .right_pwm    (right_pwm),
        .left_sample  (left_sample),
        .right_sample (right_sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .locked       (locked),
        .overrun      (overrun),
        .resync       (resync)
    );

    int    vectors = 0;
    int    miscompares = 0;
    pair_t exp_q[$];
    pair_t mon_p;

    // Reference model: a frame is the 256 input cycles starting at a left rising edge.
    bit m_lock, m_prevl, m_hv;
    int m_win, m_sl, m_sr, m_hl, m_hr, m_last_l;
    int exp_resync = 0;

    int   cyc = 0;
    int   n_overrun = 0;
    int   n_resync = 0;
    int   rise_q[$];
    int   resync_cyc_q[$];
    logic valid_prev = 1'b0;
    bit   rand_rdy = 0;
    logic rdy = 1'b1;
    logic rst_v = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_lock = 0; m_prevl = 0; m_hv = 0;
        m_win = 0; m_sl = 0; m_sr = 0; m_hl = 0; m_hr = 0;
        exp_q.delete();
    endtask

    task automatic model_push(input int sl, input int sr);
        int ol, orr;
        ol  = (sl > 255) ? 255 : sl;
        orr = (sr > 255) ? 255 : sr;
`ifdef PWM_AUDIO_IN_SMOOTH_EN
        if (m_hv) begin
            ol  = (m_hl + ol + 1) / 2;
            orr = (m_hr + orr + 1) / 2;
        end
        m_hl = ol; m_hr = orr; m_hv = 1;
`endif
        exp_q.push_back('{ol, orr});
        m_last_l = ol;
    endtask

    task automatic model_cycle(input logic l, input logic r);
        if (l && !m_prevl) begin
            if (m_lock && m_win != 0) begin
                exp_resync++;
                m_hv = 0;
            end
            m_lock = 1; m_win = 0; m_sl = 0; m_sr = 0;
        end
        m_prevl = l;
        if (m_lock) begin
            m_sl += int'(l);
            m_sr += int'(r);
            m_win++;
            if (m_win == FRAME) begin
                model_push(m_sl, m_sr);
                m_win = 0; m_sl = 0; m_sr = 0;
            end
        end
    endtask

    task automatic step(input logic l, input logic r);
        @(posedge clk);
        #1;
        aclr         = rst_v;
        left_pwm     = l;
        right_pwm    = r;
        sample_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy;
        if (rst_v) model_reset();
        else       model_cycle(l, r);
    endtask

    task automatic run_frame(input int ld, input int rd, input int roff, input int n);
        for (int i = 0; i < n; i++) begin
            step(i < ld, ((i + roff) % FRAME) < rd);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (overrun) begin
            n_overrun++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            else chk("overrun_without_pending", 1, 0);
        end
        if (resync) begin
            n_resync++;
            resync_cyc_q.push_back(cyc);
        end
        if (sample_valid && !valid_prev) rise_q.push_back(cyc);
        valid_prev = sample_valid;
        if (sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pair", 1, 0);
            end else begin
                mon_p = exp_q.pop_front();
                chk("left_sample", int'(left_sample), mon_p.l);
                chk("right_sample", int'(right_sample), mon_p.r);
            end
        end
    end

    initial begin
        int ov0;
        int inj_c;
        aclr = 1'b1; left_pwm = 1'b0; right_pwm = 1'b0; sample_ready = 1'b0;
        model_reset();
        repeat (3) step(0, 0);
        rst_v = 1'b0;
        @(negedge clk);
        chk("rst_left", int'(left_sample), 0);
        chk("rst_right", int'(right_sample), 0);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_resync", int'(resync), 0);

        repeat (1000) step(0, 0);
        @(negedge clk);
        chk("idle_locked", int'(locked), 0);
        chk("idle_valid", int'(sample_valid), 0);
        chk("idle_left", int'(left_sample), 0);

        // Steady 64/200 duty: one pair per 256 cycles.
        run_frame(64, 200, 0, FRAME);
        rise_q.delete();
        repeat (3) run_frame(64, 200, 0, FRAME);
        chk("latches_in_3_frames", rise_q.size(), 3);
        if (rise_q.size() >= 3) begin
            chk("latch_period_a", rise_q[1] - rise_q[0], FRAME);
            chk("latch_period_b", rise_q[2] - rise_q[1], FRAME);
        end

        // Left full-high (saturates), right low: no edges, lock kept.
        repeat (3) run_frame(FRAME, 0, 0, FRAME);
        chk("no_resync_full_high", n_resync, 0);

        rand_rdy = 1;
        repeat (12) run_frame($urandom_range(0, FRAME), $urandom_range(0, FRAME), $urandom_range(0, FRAME - 1), FRAME);
        rand_rdy = 0;
        rdy = 1'b1;

        // Overrun: ready low across frames of 10, 20, 30.
        ov0 = n_overrun;
        for (int i = 0; i < FRAME; i++) begin
            if (i == 10) begin
                rdy = 1'b0;
                ov0 = n_overrun;
            end
            step(i < 10, i < 77);
        end
        run_frame(20, 33, 0, FRAME);
        run_frame(30, 99, 0, FRAME);
        for (int i = 0; i < FRAME; i++) begin
            if (i == 12) rdy = 1'b1;
            if (i == 13) rdy = 1'b0;
            step(i < 150, i < 60);
            if (i == 10) begin
                @(negedge clk);
                chk("overrun_count", n_overrun - ov0, 2);
                chk("valid_held", int'(sample_valid), 1);
                chk("held_left", int'(left_sample), m_last_l);
            end
            if (i == 13) begin
                @(negedge clk);
                chk("valid_drop_after_xfer", int'(sample_valid), 0);
            end
        end

        // Mid-frame clear while a pair is pending.
        for (int i = 0; i < 128; i++) begin
            step(i < 40, i < 90);
            if (i == 20) begin
                @(negedge clk);
                chk("valid_before_clr", int'(sample_valid), 1);
            end
        end
        rst_v = 1'b1;
        step(0, 0);
        rst_v = 1'b0;
        step(0, 0);
        @(negedge clk);
        chk("clr_valid", int'(sample_valid), 0);
        chk("clr_locked", int'(locked), 0);
        chk("clr_left", int'(left_sample), 0);
        chk("clr_right", int'(right_sample), 0);

        rdy = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            step(i < 100, i < 100);
            if (i == 2) begin
                @(negedge clk);
                chk("relock_not_yet", int'(locked), 0);
            end
            if (i == 3) begin
                @(negedge clk);
                chk("relock", int'(locked), 1);
            end
        end
        run_frame(51, 51, 0, FRAME);
        run_frame(64, 200, 0, FRAME);

        // Misaligned left edge at position 100.
        for (int i = 0; i < 100; i++) step(i < 50, i < 80);
        @(negedge clk);
        #1;
        inj_c = cyc + 1;
        rise_q.delete();
        resync_cyc_q.delete();
        run_frame(64, 200, 0, FRAME);
        run_frame(64, 200, 0, FRAME);
        chk("resync_pulses", resync_cyc_q.size(), 1);
        if (resync_cyc_q.size() > 0) chk("resync_delay", resync_cyc_q[0] - inj_c, SS + 1);
        if (rise_q.size() > 0) chk("latch_after_resync", rise_q[0] - inj_c, FRAME + SS);
        else chk("latch_after_resync_seen", 0, 1);

        run_frame(0, 0, 0, 10);
        chk("queue_drained", exp_q.size(), 0);
        chk("resync_total", n_resync, exp_resync);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_audio_stereo_in.md
# pwm_audio_stereo_in

Stereo PWM audio receiver: recovers 8-bit left/right samples from two PWM lines by counting high-time over fixed 256-cycle frames. It sits at the input side of the audio path, as the receiving end of the stereo PWM output link. It hands one sample pair per frame to downstream logic over a valid/ready handshake.

## Interface
- `PWM_BITS`, 8: frame length is 2^PWM_BITS cycles; sample width.
- `SYNC_STAGES`, 2: flip-flop synchronizer depth on each PWM input (min 2).
- `clk` in 1: sole clock.
- `aclr` in 1: reset, synchronous, active-high.
- `left_pwm` in 1: left PWM line, asynchronous to `clk`.
- `right_pwm` in 1: right PWM line, asynchronous to `clk`.
- `left_sample` out PWM_BITS: recovered left duty value.
- `right_sample` out PWM_BITS: recovered right duty value.
- `sample_valid` out 1: sample pair available; held until accepted.
- `sample_ready` in 1: downstream accepts the pair when high with `sample_valid`.
- `locked` out 1: frame alignment acquired.
- `overrun` out 1: one-cycle pulse when an unaccepted pair is overwritten.
- `resync` out 1: one-cycle pulse when lock is dropped by a misaligned edge.

## Operation
- Each input passes through its own SYNC_STAGES synchronizer. A rising edge is synchronized-now-high and previous-low.
- FSM states: HUNT and LOCK.
- HUNT: the frame counter is idle; accumulators are held at 0. On the first left rising edge, go to LOCK with `frame_cnt`=0. That edge cycle counts as position 0 and is accumulated.
- LOCK: `frame_cnt` increments every cycle and wraps 2^PWM_BITS-1 -> 0.
  - Per channel, the accumulator adds 1 for each cycle the synchronized line is high.
  - At position 0 the accumulator loads the current bit (0 or 1) instead of adding.
- Frame end (`frame_cnt`=2^PWM_BITS-1): the accumulated count, including that cycle's bit, is latched.
  - Count range is 0..256; 256 saturates to 255.
- Boundary conditions:
  - A frame with no edges (duty 0 or full high) is valid. It produces 0 or 255 respectively and does not affect lock.
  - A left rising edge in LOCK with `frame_cnt`≠0: pulse `resync`, discard the partial frame, and restart a frame at that edge. Stay in LOCK with `frame_cnt`=0, accumulating that cycle.
  - Right-channel edges never affect alignment.
- Handshake:
  - A transfer occurs on a cycle with `sample_valid`&&`sample_ready`. `sample_valid` then drops next cycle, unless a latch happens on the same cycle.
  - Latch while `sample_valid`=0: update the samples and set `sample_valid`.
  - Latch while `sample_valid`=1 and `sample_ready`=0: overwrite the samples, pulse `overrun`, and keep `sample_valid`=1.
  - Latch on the same cycle as a transfer: the transfer takes the old pair; the new pair loads and `sample_valid` stays 1; no overrun.
- `locked` = (state==LOCK).
- `aclr` high on any cycle, including mid-frame: synchronizers, counters and accumulators clear, state goes to HUNT, and all outputs go to 0. Any pending sample is lost.

## Timing
- Reset values: `left_sample`=0, `right_sample`=0, `sample_valid`=0, `locked`=0, `overrun`=0, `resync`=0.
- Input to synchronized bit: SYNC_STAGES cycles.
- Outputs update on the clock edge after the frame-end cycle.
  - `sample_valid` rises that same edge.
  - `overrun` is asserted for exactly that one cycle.
- `locked` rises the cycle after the HUNT edge is detected.
- `resync` is asserted the cycle after the misaligned edge is detected.
- Steady state: exactly one latch per 2^PWM_BITS cycles.

## Configuration
- `PWM_AUDIO_IN_SMOOTH_EN` defined: each latched value is (previous latched + current + 1) >> 1 per channel, computed at PWM_BITS+1 width.
  - The smoothing history clears on reset and on `resync`. The first frame after a clear is output unsmoothed.
- Not defined: the raw saturated count is output directly; no history registers exist.

## Structure
- Shared package `pwm_audio_pkg`:
  - `PWM_BITS` default constant.
  - FSM state enum (HUNT, LOCK).
  - Saturation-to-PWM_BITS helper function.
- Sub-module `pwm_duty_counter`, instantiated once per channel, contains:
  - the synchronizer and edge detect;
  - the accumulator with load-at-position-0;
  - saturation and optional smoothing.
- The top level holds the FSM, `frame_cnt`, and the handshake.

## Test plan
- Reset then idle lines for 1000 cycles -> `locked`=0, `sample_valid`=0, all outputs 0.
- Left PWM with 64 high / 192 low per 256, right 200 high, `sample_ready`=1 -> after lock, every frame yields left=64, right=200, `sample_valid` pulsing once per 256 cycles.
- After lock, left held constantly high and right held low -> left=255, right=0 each frame; no `resync`.
- Hold `sample_ready`=0 across 3 frames of left=10 then 20 then 30 -> `overrun` pulses twice; the pair presented is 30; assert ready -> one transfer, then `sample_valid` drops.
- Inject a left rising edge at `frame_cnt`=100 -> `resync` pulses one cycle; the next latched sample comes 256 cycles after the injected edge.
- Assert `aclr` for 1 cycle mid-frame while `sample_valid`=1 -> all outputs 0 the next cycle, state HUNT; relock on the next left edge.
- With `PWM_AUDIO_IN_SMOOTH_EN`: frames 100 then 51 -> outputs 100 then 76.
